pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised round-based pipeline sequencer for the in-order core: replaces hand-written per-stage enable/reset/latch logic with a generic N-stage controller. It decides each round whether to advance, stall for a load-use hazard or flush on a taken jump. It drives per-stage enable pulses, bubble (reset) levels and pipeline-register capture strobes, and it owns the PC and the retired/stall/flush counters.

## Interface
Parameters:
- NSTAGES, 5, number of stages; stage 0 is fetch and stage NSTAGES-1 is writeback; must be >= 4.
- EX_STAGE, 2, index of the stage that resolves jumps and detects load-use; must satisfy 2 <= EX_STAGE <= NSTAGES-2.
- RESET_PC, 32'h0, PC value loaded at reset.
- PC_STEP, 4, PC increment applied on a normal advance.
- CNT_W, 64, width of each performance counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- stage_done  in  NSTAGES  per-stage completion level. A stage drops it in the cycle after it samples its enable high, and raises it again when its work finishes.
- hazard_lu  in  1  the instruction in EX_STAGE is a load and the instruction in EX_STAGE-1 reads its rd.
- jump_taken  in  1  the instruction in EX_STAGE redirects control flow.
- jump_dest  in  32  redirect target.
- stage_en  out  NSTAGES  one-cycle start pulse per stage.
- stage_bubble  out  NSTAGES  level; 1 means the stage holds no valid instruction and is held in reset.
- stage_latch  out  NSTAGES  combinational strobe; bit i (i>=1) tells the datapath to capture the outputs of stage i-1 into the input register of stage i at this clock edge. Bit 0 is always 0.
- pc  out  32  fetch address.
- stalling  out  1  the controller is in state STALL.
- retired  out  CNT_W  count of retired instructions.
- stall_cnt  out  CNT_W  count of load-use stalls.
- flush_cnt  out  CNT_W  count of jump flushes.

## Operation
- Round ready: ready = (stage_en == 0) && &(stage_done | stage_bubble). Bubbled stages are ignored.
- A step occurs in any cycle in which ready is 1. All decisions below use the register values present in that cycle; b is stage_bubble before the step and b' is its value after.
- The FSM has two states, NORMAL and STALL. Step cases, first match wins:
  - **STALL state (post-stall release):** perform a normal advance, ignore hazard_lu and jump_taken, and return to NORMAL.
  - **hazard_lu && !b[EX_STAGE] (load-use):**
    - pc is held.
    - b'[0..EX_STAGE-1] = b; b'[EX_STAGE] = 1; b'[i] = b[i-1] for i > EX_STAGE.
    - stage_en[0] = 0; stage_en[1..EX_STAGE-1] = !b' (these stages rerun on their unchanged inputs); stage_en[i] = !b'[i] for i > EX_STAGE.
    - stage_latch is 1 only for i > EX_STAGE.
    - Go to STALL and increment stall_cnt.
  - **jump_taken && !b[EX_STAGE] (flush):**
    - pc <= jump_dest.
    - b'[0] = 0; b'[1..EX_STAGE] = 1; b'[i] = b[i-1] for i > EX_STAGE.
    - stage_en[0] = 1; stage_en[i] = !b'[i] for i > EX_STAGE; all other enables 0.
    - stage_latch is 1 only for i > EX_STAGE.
    - Increment flush_cnt.
  - **Otherwise (normal advance):**
    - pc <= pc + PC_STEP.
    - b'[0] = 0; b'[i] = b[i-1] for i >= 1.
    - stage_en = ~b'.
    - stage_latch[i] = 1 for all i >= 1.
- Retire: on any step with !b[NSTAGES-1], retired increments by exactly 1.
- If hazard_lu and jump_taken are both asserted, load-use wins and the jump is discarded (this combination is a protocol error).
- Arithmetic: pc wraps modulo 2^32. All counters wrap modulo 2^CNT_W.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-round):
  - pc = RESET_PC.
  - stage_en = 1 (fetch only).
  - stage_bubble = all ones except bit 0.
  - state = NORMAL, stalling = 0.
  - All counters = 0.
  - stage_latch evaluates to 0.
- A step in cycle t produces registered stage_en, stage_bubble, pc and counter values visible in cycle t+1. stage_en returns to 0 in cycle t+2.
- stage_latch is high only in cycle t.
- ready is forced to 0 in cycle t+1 while stage_en is nonzero, so stale done levels are never sampled.
- Minimum round length is 2 cycles, reached when all stages report done in the cycle after their enable.
- While not ready: all outputs hold and stage_en = 0.

## Test plan
- Reset mid-round: rstn low at an arbitrary cycle with stages busy -> in the same cycle pc=0, stage_en=5'b00001, stage_bubble=5'b11110, all counters 0.
- Straight line, stage_done raised one cycle after enable, no hazards -> steps every 2 cycles. After 4 steps stage_bubble=0 and pc=16. retired first increments on the 5th step and then by 1 per step.
- Load-use at step k with pc=0x40 -> pc remains 0x40, stage_bubble[2]=1, stage_en[0]=0, stage_en[1]=1, stall_cnt=1, stalling=1. The next step gives pc=0x44 and stalling=0.
- Jump at pc=0x20 with jump_dest=0x100 -> pc=0x100, stage_bubble[2:1]=2'b11, stage_en[0]=1, flush_cnt=1, stage_latch[4:3]=2'b11 and stage_latch[2:1]=0.
- hazard_lu and jump_taken asserted together -> load-use behaviour as above, pc not redirected, flush_cnt unchanged.
- Slow stage: stage 3 raises stage_done 10 cycles late -> no step in the meantime; stage 3's done is ignored while stage_bubble[3]=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Generic N-stage round-based pipeline sequencer: decides advance / load-use stall /
// jump flush each round and drives stage enables, bubbles, latch strobes, PC and counters.
module pipe_ctrl #(
    parameter int          NSTAGES  = 5,
    parameter int          EX_STAGE = 2,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          PC_STEP  = 4,
    parameter int          CNT_W    = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NSTAGES-1:0] stage_done,
    input  logic               hazard_lu,
    input  logic               jump_taken,
    input  logic [31:0]        jump_dest,
    output logic [NSTAGES-1:0] stage_en,
    output logic [NSTAGES-1:0] stage_bubble,
    output logic [NSTAGES-1:0] stage_latch,
    output logic [31:0]        pc,
    output logic               stalling,
    output logic [CNT_W-1:0]   retired,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [NSTAGES-1:0] EN_RESET  = {{(NSTAGES-1){1'b0}}, 1'b1};
    localparam logic [NSTAGES-1:0] BUB_RESET = {{(NSTAGES-1){1'b1}}, 1'b0};
    localparam logic [31:0]        PC_INC    = 32'(PC_STEP);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_NORMAL,
        ST_STALL
    } state_t;

    typedef enum logic [1:0] {
        STEP_ADV,
        STEP_LU,
        STEP_JMP
    } step_t;

    state_t             state_reg, state_next;
    step_t              step_kind;
    logic [NSTAGES-1:0] en_reg, en_next;
    logic [NSTAGES-1:0] bubble_reg, bubble_next;
    logic [31:0]        pc_reg, pc_next;
    logic [CNT_W-1:0]   retired_reg, stall_cnt_reg, flush_cnt_reg;
    logic               ready;

    // Candidate next-round values for each of the three step kinds, built per stage.
    logic [NSTAGES-1:0] bub_adv, bub_lu, bub_jmp;
    logic [NSTAGES-1:0] en_adv, en_lu, en_jmp;
    logic [NSTAGES-1:0] lat_adv, lat_back;

    // Enables still high means the done levels are stale from the previous round.
    assign ready = (en_reg == '0) && (&(stage_done | bubble_reg));

    generate
        for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_fetch
                assign bub_adv[gi]  = 1'b0;
                assign bub_lu[gi]   = bubble_reg[gi];
                assign bub_jmp[gi]  = 1'b0;
                assign en_adv[gi]   = 1'b1;
                assign en_lu[gi]    = 1'b0;
                assign en_jmp[gi]   = 1'b1;
                assign lat_adv[gi]  = 1'b0;
                assign lat_back[gi] = 1'b0;
            end else if (gi < EX_STAGE) begin : g_front
                // On a load-use stall these stages keep their instruction and rerun it.
                assign bub_adv[gi]  = bubble_reg[gi-1];
                assign bub_lu[gi]   = bubble_reg[gi];
                assign bub_jmp[gi]  = 1'b1;
                assign en_adv[gi]   = ~bubble_reg[gi-1];
                assign en_lu[gi]    = ~bubble_reg[gi];
                assign en_jmp[gi]   = 1'b0;
                assign lat_adv[gi]  = 1'b1;
                assign lat_back[gi] = 1'b0;
            end else if (gi == EX_STAGE) begin : g_ex
                assign bub_adv[gi]  = bubble_reg[gi-1];
                assign bub_lu[gi]   = 1'b1;
                assign bub_jmp[gi]  = 1'b1;
                assign en_adv[gi]   = ~bubble_reg[gi-1];
                assign en_lu[gi]    = 1'b0;
                assign en_jmp[gi]   = 1'b0;
                assign lat_adv[gi]  = 1'b1;
                assign lat_back[gi] = 1'b0;
            end else begin : g_back
                // Past EX the pipeline always drains forward, whatever the step kind.
                assign bub_adv[gi]  = bubble_reg[gi-1];
                assign bub_lu[gi]   = bubble_reg[gi-1];
                assign bub_jmp[gi]  = bubble_reg[gi-1];
                assign en_adv[gi]   = ~bubble_reg[gi-1];
                assign en_lu[gi]    = ~bubble_reg[gi-1];
                assign en_jmp[gi]   = ~bubble_reg[gi-1];
                assign lat_adv[gi]  = 1'b1;
                assign lat_back[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        step_kind   = STEP_ADV;
        en_next     = en_adv;
        bubble_next = bub_adv;
        pc_next     = pc_reg + PC_INC;

        if (state_reg == ST_STALL) begin
            step_kind  = STEP_ADV;
            state_next = ST_NORMAL;
        end else if (hazard_lu && !bubble_reg[EX_STAGE]) begin
            step_kind  = STEP_LU;
            state_next = ST_STALL;
        end else if (jump_taken && !bubble_reg[EX_STAGE]) begin
            step_kind = STEP_JMP;
        end

        case (step_kind)
            STEP_LU: begin
                en_next     = en_lu;
                bubble_next = bub_lu;
                pc_next     = pc_reg;
            end
            STEP_JMP: begin
                en_next     = en_jmp;
                bubble_next = bub_jmp;
                pc_next     = jump_dest;
            end
            default: begin
                en_next     = en_adv;
                bubble_next = bub_adv;
                pc_next     = pc_reg + PC_INC;
            end
        endcase
    end

    always_comb begin
        stage_latch = '0;
        if (ready) begin
            stage_latch = (step_kind == STEP_ADV) ? lat_adv : lat_back;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_NORMAL;
            en_reg        <= EN_RESET;
            bubble_reg    <= BUB_RESET;
            pc_reg        <= RESET_PC;
            retired_reg   <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (ready) begin
            state_reg  <= state_next;
            en_reg     <= en_next;
            bubble_reg <= bubble_next;
            pc_reg     <= pc_next;
            if (!bubble_reg[NSTAGES-1]) begin
                retired_reg <= retired_reg + CNT_ONE;
            end
            if (step_kind == STEP_LU) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
            if (step_kind == STEP_JMP) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
            end
        end else begin
            en_reg <= '0;
        end
    end

    assign stage_en     = en_reg;
    assign stage_bubble = bubble_reg;
    assign pc           = pc_reg;
    assign stalling     = (state_reg == ST_STALL);
    assign retired      = retired_reg;
    assign stall_cnt    = stall_cnt_reg;
    assign flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: emulated stages plus an instruction-slot occupancy model
// compared against every registered output and the latch strobes each cycle.
module tb_pipe_ctrl;

    localparam int          N     = 5;
    localparam int          EX    = 2;
    localparam int          CW    = 64;
    localparam logic [31:0] RPC   = 32'h0;
    localparam int          PSTEP = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  stage_done;
    logic          hazard_lu;
    logic          jump_taken;
    logic [31:0]   jump_dest;
    logic [N-1:0]  stage_en;
    logic [N-1:0]  stage_bubble;
    logic [N-1:0]  stage_latch;
    logic [31:0]   pc;
    logic          stalling;
    logic [CW-1:0] retired;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NSTAGES (N),
        .EX_STAGE(EX),
        .RESET_PC(RPC),
        .PC_STEP (PSTEP),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stage_done  (stage_done),
        .hazard_lu   (hazard_lu),
        .jump_taken  (jump_taken),
        .jump_dest   (jump_dest),
        .stage_en    (stage_en),
        .stage_bubble(stage_bubble),
        .stage_latch (stage_latch),
        .pc          (pc),
        .stalling    (stalling),
        .retired     (retired),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Model: which stages hold a valid instruction, which were started this round.
    bit            m_vld[N];
    logic [N-1:0]  m_en;
    logic [31:0]   m_pc;
    bit            m_stall;
    logic [CW-1:0] m_ret, m_stl, m_fls;
    int            steps;

    // Stage emulation: remaining busy cycles per stage.
    int rem[N];
    int dly_max;
    bit force3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] bub_mask();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = !m_vld[i];
        return b;
    endfunction

    function automatic int pick_delay(input int i);
        if (dly_max == 0) return 0;
        if (i == 3 && $urandom_range(0, 7) == 0) return 10;
        return $urandom_range(0, dly_max);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = (i == 0);
            rem[i]   = 0;
        end
        m_en    = 1;
        m_pc    = RPC;
        m_stall = 0;
        m_ret   = 0;
        m_stl   = 0;
        m_fls   = 0;
    endtask

    task automatic do_cycle(input bit hz, input bit jp, input logic [31:0] dest);
        logic [N-1:0] dv, b, exp_lat, starts;
        bit           nv[N];
        bit           rdy;
        int           kind;
        @(negedge clk);
        b = bub_mask();
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0) begin
                dv[i] = 1'b0;
                rem[i]--;
            end else begin
                dv[i] = 1'b1;
            end
            if (b[i] && dly_max > 0) dv[i] = 1'($urandom_range(0, 1));
        end
        if (force3 && b[3]) dv[3] = 1'b0;
        stage_done = dv;
        hazard_lu  = hz;
        jump_taken = jp;
        jump_dest  = dest;
        #1;
        chk("stage_en", stage_en, m_en);
        chk("stage_bubble", stage_bubble, b);
        chk("pc", pc, m_pc);
        chk("stalling", stalling, m_stall);
        chk("retired", retired, m_ret);
        chk("stall_cnt", stall_cnt, m_stl);
        chk("flush_cnt", flush_cnt, m_fls);

        rdy     = (m_en == 0) && (&(dv | b));
        exp_lat = '0;
        starts  = '0;
        if (rdy) begin
            if (m_vld[N-1]) m_ret++;
            if (m_stall) kind = 0;
            else if (hz && m_vld[EX]) kind = 1;
            else if (jp && m_vld[EX]) kind = 2;
            else kind = 0;
            for (int i = EX + 1; i < N; i++) nv[i] = m_vld[i-1];
            if (kind == 0) begin
                nv[0] = 1;
                for (int i = 1; i <= EX; i++) nv[i] = m_vld[i-1];
                for (int i = 0; i < N; i++) starts[i] = nv[i];
                for (int i = 1; i < N; i++) exp_lat[i] = 1'b1;
                m_pc    = m_pc + PSTEP;
                m_stall = 0;
            end else if (kind == 1) begin
                for (int i = 0; i < EX; i++) nv[i] = m_vld[i];
                nv[EX] = 0;
                for (int i = 1; i < N; i++) starts[i] = nv[i];
                for (int i = EX + 1; i < N; i++) exp_lat[i] = 1'b1;
                m_stall = 1;
                m_stl++;
            end else begin
                nv[0] = 1;
                for (int i = 1; i <= EX; i++) nv[i] = 0;
                starts[0] = 1'b1;
                for (int i = EX + 1; i < N; i++) begin
                    starts[i]  = nv[i];
                    exp_lat[i] = 1'b1;
                end
                m_pc = dest;
                m_fls++;
            end
            m_vld = nv;
            m_en  = starts;
            steps++;
            $display("step %0d kind=%0d hz=%0b jp=%0b pc_after=%h en=%b bub=%b",
                     steps, kind, hz, jp, m_pc, m_en, bub_mask());
        end else begin
            m_en = '0;
        end
        chk("stage_latch", stage_latch, exp_lat);
        for (int i = 0; i < N; i++) begin
            if (stage_en[i]) rem[i] = pick_delay(i);
        end
    endtask

    task automatic run_until_step(input bit hz, input bit jp, input logic [31:0] dest);
        int s0;
        s0 = steps;
        for (int c = 0; c < 100 && steps == s0; c++) do_cycle(hz, jp, dest);
        chk("step_timeout", steps - s0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pc(input logic [31:0] target);
        for (int c = 0; c < 400 && m_pc != target; c++) do_cycle(0, 0, 0);
        chk("pc_timeout", m_pc, target);
    endtask

    initial begin
        rstn       = 1'b1;
        stage_done = '1;
        hazard_lu  = 1'b0;
        jump_taken = 1'b0;
        jump_dest  = '0;
        steps      = 0;
        dly_max    = 0;
        force3     = 0;
        model_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_en", stage_en, 5'b00001);
        chk("rst_bubble", stage_bubble, 5'b11110);
        chk("rst_latch", stage_latch, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;

        // Straight line, 2-cycle rounds; stage 3 done held low while it is a bubble.
        force3 = 1;
        for (int c = 0; c < 100 && steps < 4; c++) do_cycle(0, 0, 0);
        @(posedge clk);
        #1;
        chk("straight_pc16", pc, 32'd16);
        chk("straight_bub0", stage_bubble, 0);
        chk("straight_ret0", retired, 0);
        force3 = 0;
        run_until_step(0, 0, 0);
        chk("straight_ret1", retired, 1);

        // Jump at pc 0x20 to 0x100.
        run_until_pc(32'h20);
        run_until_step(0, 1, 32'h100);
        chk("jmp_pc", pc, 32'h100);
        chk("jmp_bub21", stage_bubble[2:1], 2'b11);
        chk("jmp_en0", stage_en[0], 1'b1);
        chk("jmp_flush", flush_cnt, 1);

        // Busy stages, then reset mid-round.
        dly_max = 3;
        for (int c = 0; c < 7; c++) do_cycle(0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_pc", pc, RPC);
        chk("mid_rst_en", stage_en, 5'b00001);
        chk("mid_rst_bubble", stage_bubble, 5'b11110);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_flush", flush_cnt, 0);
        chk("mid_rst_stalling", stalling, 0);
        model_reset();
        dly_max = 0;
        @(posedge clk);
        #2 rstn = 1'b1;

        // Load-use at pc 0x40.
        run_until_pc(32'h40);
        run_until_step(1, 0, 0);
        chk("lu_pc", pc, 32'h40);
        chk("lu_bub2", stage_bubble[2], 1'b1);
        chk("lu_en0", stage_en[0], 1'b0);
        chk("lu_en1", stage_en[1], 1'b1);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_stalling", stalling, 1'b1);
        run_until_step(0, 0, 0);
        chk("lu_release_pc", pc, 32'h44);
        chk("lu_release_stalling", stalling, 1'b0);

        // Hazard and jump together: load-use wins.
        run_until_pc(32'h60);
        run_until_step(1, 1, 32'h200);
        chk("both_pc", pc, 32'h60);
        chk("both_flush", flush_cnt, 0);
        chk("both_stall_cnt", stall_cnt, 2);

        // Randomized traffic including pc wrap targets and slow stages.
        dly_max = 3;
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            do_cycle($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
